// File: rtl/instruction_fetch.sv
// Instruction fetch stage: byte-wise program loader, PC register and instruction memory.
// Optional IF_HALT_DETECT_EN: an all-ones instruction fetched in RUN parks the stage in HALT.
module instruction_fetch #(
    parameter int PC_SIZE          = 32,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int MEM_WORDS        = 64
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_stall,
    input  logic                        i_pc_src,
    input  logic [PC_SIZE-1:0]          i_not_seq_pc,
    input  logic                        i_wr_en,
    input  logic [7:0]                  i_wr_byte,
    input  logic                        i_start,
    input  logic                        i_clear,
    output logic [PC_SIZE-1:0]          o_next_seq_pc,
    output logic [INSTRUCTION_SIZE-1:0] o_instruction,
    output logic [PC_SIZE-1:0]          o_pc,
    output logic                        o_mem_full,
    output logic                        o_mem_empty,
    output logic                        o_halt
);

    // state   | meaning
    // LOAD    | program bytes accepted, PC held at 0
    // RUN     | fetching, PC steps on enable and no stall
    // HALT    | all-ones instruction seen, PC frozen until clear/reset
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = AW + 1;
    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]                  r_state;
    logic [PC_SIZE-1:0]          r_pc;
    logic [CW-1:0]               r_word_count;
    logic [23:0]                 r_asm;
    logic [1:0]                  r_byte_cnt;
    logic [INSTRUCTION_SIZE-1:0] r_mem [MEM_WORDS];

    logic [AW-1:0] w_idx;
    logic          w_full;
    logic          w_empty;
    logic          w_load_byte;
    logic          w_commit;
    logic          w_step;
    logic          w_halt_hit;

    assign w_idx       = r_pc[AW+1:2];
    assign w_full      = (r_word_count == CW'(MEM_WORDS));
    assign w_empty     = (r_word_count == '0);
    assign w_load_byte = (r_state == ST_LOAD) && i_wr_en && !w_full;
    assign w_commit    = w_load_byte && (r_byte_cnt == 2'd3);
    assign w_step      = (r_state == ST_RUN) && i_enable && !i_stall;

    assign o_pc          = r_pc;
    assign o_next_seq_pc = r_pc + PC_SIZE'(4);
    assign o_mem_full    = w_full;
    assign o_mem_empty   = w_empty;
    // Slots at or beyond the loaded count read as NOP, whatever stale data the array holds.
    assign o_instruction = ({1'b0, w_idx} < r_word_count) ? r_mem[w_idx] : '0;

`ifdef IF_HALT_DETECT_EN
    assign w_halt_hit = w_step && (o_instruction == '1);
    assign o_halt     = (r_state == ST_HALT);
`else
    assign w_halt_hit = 1'b0;
    assign o_halt     = 1'b0;
`endif

    // Array has no reset so a reset does not disturb the stored program contents.
    always_ff @(posedge i_clk) begin
        if (i_reset && !i_clear && (r_state == ST_LOAD) && i_start && !w_empty) begin
            // start wins over a same-cycle byte; nothing is written
        end else if (i_reset && !i_clear && w_commit) begin
            r_mem[r_word_count[AW-1:0]] <= INSTRUCTION_SIZE'({r_asm, i_wr_byte});
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clear) begin
            r_state      <= ST_LOAD;
            r_pc         <= '0;
            r_word_count <= '0;
            r_asm        <= '0;
            r_byte_cnt   <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (i_start && !w_empty) begin
                        r_state    <= ST_RUN;
                        r_asm      <= '0;
                        r_byte_cnt <= '0;
                    end else if (w_commit) begin
                        r_word_count <= r_word_count + CW'(1);
                        r_asm        <= '0;
                        r_byte_cnt   <= '0;
                    end else if (w_load_byte) begin
                        r_asm      <= {r_asm[15:0], i_wr_byte};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                ST_RUN: begin
                    if (w_halt_hit) begin
                        r_state <= ST_HALT;
                    end else if (w_step) begin
                        r_pc <= i_pc_src ? i_not_seq_pc : (r_pc + PC_SIZE'(4));
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch (default parameters).
`timescale 1ns/1ps
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0, stall = 1'b0, pc_src = 1'b0;
    logic [31:0] target = 32'h0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_byte = 8'h0;
    logic        start = 1'b0, clear = 1'b0;
    logic [31:0] next_seq_pc, instruction, pc;
    logic        mem_full, mem_empty, halt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.PC_SIZE(32), .INSTRUCTION_SIZE(32), .MEM_WORDS(64)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_enable(enable), .i_stall(stall),
        .i_pc_src(pc_src), .i_not_seq_pc(target), .i_wr_en(wr_en), .i_wr_byte(wr_byte),
        .i_start(start), .i_clear(clear), .o_next_seq_pc(next_seq_pc),
        .o_instruction(instruction), .o_pc(pc), .o_mem_full(mem_full),
        .o_mem_empty(mem_empty), .o_halt(halt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; step(); rst_n = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en = 1'b1; wr_byte = b; step(); wr_en = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        write_byte(w[31:24]); write_byte(w[23:16]); write_byte(w[15:8]); write_byte(w[7:0]);
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic run_cycle(input logic src, input logic [31:0] tgt, input logic stl);
        enable = 1'b1; pc_src = src; target = tgt; stall = stl;
        step();
        enable = 1'b0; pc_src = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset();
        wr_en = 1'b1; wr_byte = 8'hEE; enable = 1'b1; start = 1'b1;
        do_reset();
        wr_en = 1'b0; enable = 1'b0; start = 1'b0;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        checks++; if (next_seq_pc !== 32'h4) begin errors++; $display("FAIL reset_nseq got %h exp %h", next_seq_pc, 32'h4); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp %h", instruction, 32'h0); end
        checks++; if ({mem_empty, mem_full, halt} !== 3'b100) begin errors++; $display("FAIL reset_flags got %b exp %b", {mem_empty, mem_full, halt}, 3'b100); end
    endtask

    task automatic test_load_basic();
        do_reset();
        write_word(32'h12345678);
        do_start();
        checks++; if (instruction !== 32'h12345678) begin errors++; $display("FAIL load_instr got %h exp %h", instruction, 32'h12345678); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL load_pc got %h exp %h", pc, 32'h0); end
        checks++; if (next_seq_pc !== 32'h4) begin errors++; $display("FAIL load_nseq got %h exp %h", next_seq_pc, 32'h4); end
        checks++; if (mem_empty !== 1'b0) begin errors++; $display("FAIL load_empty got %b exp 0", mem_empty); end
    endtask

    task automatic test_sequential();
        do_reset();
        write_word(32'h11111111); write_word(32'h22222222);
        do_start();
        checks++; if (instruction !== 32'h11111111) begin errors++; $display("FAIL seq_i0 got %h exp %h", instruction, 32'h11111111); end
        run_cycle(1'b0, 32'h0, 1'b0);
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc1 got %h exp %h", pc, 32'h4); end
        checks++; if (instruction !== 32'h22222222) begin errors++; $display("FAIL seq_i1 got %h exp %h", instruction, 32'h22222222); end
        run_cycle(1'b0, 32'h0, 1'b0);
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc2 got %h exp %h", pc, 32'h8); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL seq_i2_nop got %h exp %h", instruction, 32'h0); end
        run_cycle(1'b0, 32'h0, 1'b0);
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL seq_pc3 got %h exp %h", pc, 32'hC); end
        checks++; if (next_seq_pc !== 32'h10) begin errors++; $display("FAIL seq_nseq3 got %h exp %h", next_seq_pc, 32'h10); end
        step();
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL seq_disabled_hold got %h exp %h", pc, 32'hC); end
    endtask

    task automatic test_stall_redirect();
        run_cycle(1'b1, 32'h10, 1'b1);
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL stall_hold got %h exp %h", pc, 32'hC); end
        run_cycle(1'b1, 32'h10, 1'b0);
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL redirect got %h exp %h", pc, 32'h10); end
        run_cycle(1'b0, 32'h0, 1'b1);
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_seq_hold got %h exp %h", pc, 32'h10); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            checks++; if (mem_full !== 1'b0) begin errors++; $display("FAIL full_early word %0d got %b exp 0", i, mem_full); end
            write_word(32'hA5000000 | i);
        end
        checks++; if (mem_full !== 1'b1) begin errors++; $display("FAIL full_set got %b exp 1", mem_full); end
        write_word(32'hDEADBEEF);
        checks++; if ({mem_full, mem_empty} !== 2'b10) begin errors++; $display("FAIL full_after_extra got %b exp %b", {mem_full, mem_empty}, 2'b10); end
        checks++; if (instruction !== 32'hA5000000) begin errors++; $display("FAIL full_word0 got %h exp %h", instruction, 32'hA5000000); end
        do_start();
        run_cycle(1'b1, 32'hFFFFFFFC, 1'b0);
        checks++; if (instruction !== 32'hA500003F) begin errors++; $display("FAIL full_word63 got %h exp %h", instruction, 32'hA500003F); end
        checks++; if (next_seq_pc !== 32'h0) begin errors++; $display("FAIL wrap_nseq got %h exp %h", next_seq_pc, 32'h0); end
        run_cycle(1'b0, 32'h0, 1'b0);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp %h", pc, 32'h0); end
        run_cycle(1'b1, 32'h0000000B, 1'b0);
        checks++; if (instruction !== 32'hA5000002) begin errors++; $display("FAIL lowbits_ignored got %h exp %h", instruction, 32'hA5000002); end
        run_cycle(1'b1, 32'h00000104, 1'b0);
        checks++; if (instruction !== 32'hA5000001) begin errors++; $display("FAIL index_wrap got %h exp %h", instruction, 32'hA5000001); end
    endtask

    task automatic test_clear();
        clear = 1'b1; start = 1'b1; wr_en = 1'b1; wr_byte = 8'h77; enable = 1'b1;
        step();
        clear = 1'b0; start = 1'b0; wr_en = 1'b0; enable = 1'b0;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL clear_pc got %h exp %h", pc, 32'h0); end
        checks++; if ({mem_empty, mem_full} !== 2'b10) begin errors++; $display("FAIL clear_flags got %b exp %b", {mem_empty, mem_full}, 2'b10); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL clear_instr got %h exp %h", instruction, 32'h0); end
        do_start();
        run_cycle(1'b0, 32'h0, 1'b0);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL start_empty_ignored got %h exp %h", pc, 32'h0); end
        write_word(32'h01020304);
        checks++; if (instruction !== 32'h01020304) begin errors++; $display("FAIL clear_reload got %h exp %h", instruction, 32'h01020304); end
        checks++; if (mem_empty !== 1'b0) begin errors++; $display("FAIL clear_reload_empty got %b exp 0", mem_empty); end
    endtask

    task automatic test_reset_midload();
        do_reset();
        write_byte(8'h99); write_byte(8'h88);
        wr_en = 1'b1; wr_byte = 8'h77;
        do_reset();
        wr_en = 1'b0;
        checks++; if (mem_empty !== 1'b1) begin errors++; $display("FAIL midload_empty got %b exp 1", mem_empty); end
        write_word(32'hAABBCCDD);
        do_start();
        checks++; if (instruction !== 32'hAABBCCDD) begin errors++; $display("FAIL midload_instr got %h exp %h", instruction, 32'hAABBCCDD); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL midload_pc got %h exp %h", pc, 32'h0); end
    endtask

    task automatic test_halt();
        do_reset();
        write_word(32'h00000000); write_word(32'hFFFFFFFF);
        do_start();
        run_cycle(1'b0, 32'h0, 1'b0);
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL halt_pc4 got %h exp %h", pc, 32'h4); end
        checks++; if (instruction !== 32'hFFFFFFFF) begin errors++; $display("FAIL halt_instr got %h exp %h", instruction, 32'hFFFFFFFF); end
        run_cycle(1'b0, 32'h0, 1'b0);
`ifdef IF_HALT_DETECT_EN
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_set got %b exp 1", halt); end
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL halt_pc_frozen got %h exp %h", pc, 32'h4); end
        run_cycle(1'b1, 32'h20, 1'b0);
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL halt_redirect_ignored got %h exp %h", pc, 32'h4); end
        do_clear();
        checks++; if ({halt, mem_empty} !== 2'b01) begin errors++; $display("FAIL halt_clear_flags got %b exp %b", {halt, mem_empty}, 2'b01); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL halt_clear_pc got %h exp %h", pc, 32'h0); end
`else
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL nohalt_flag got %b exp 0", halt); end
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL nohalt_pc got %h exp %h", pc, 32'h8); end
`endif
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        test_reset();
        test_load_basic();
        test_sequential();
        test_stall_redirect();
        test_full();
        test_clear();
        test_reset_midload();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter PC_SIZE, default 32, program counter and sequential-PC width.
REQ-002 Parameter INSTRUCTION_SIZE, default 32, fetched instruction width.
REQ-003 Parameter MEM_WORDS, default 64, instruction memory depth in words, power of two.
REQ-004 i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 i_reset  in  1  reset, synchronous, active-low.
REQ-006 i_enable  in  1  pipeline step enable; PC advances only when high.
REQ-007 i_stall  in  1  hazard stall; holds PC when high.
REQ-008 i_pc_src  in  1  1 = take i_not_seq_pc, 0 = sequential PC+4.
REQ-009 i_not_seq_pc  in  PC_SIZE  branch/jump target.
REQ-010 i_wr_en  in  1  program-load byte strobe.
REQ-011 i_wr_byte  in  8  program-load byte.
REQ-012 i_start  in  1  leave LOAD, begin fetching.
REQ-013 i_clear  in  1  discard program, return to LOAD.
REQ-014 o_next_seq_pc  out  PC_SIZE  PC+4 of current instruction, to IF/ID register.
REQ-015 o_instruction  out  INSTRUCTION_SIZE  word at current PC, to IF/ID register.
REQ-016 o_pc  out  PC_SIZE  current PC.
REQ-017 o_mem_full  out  1  loaded word count == MEM_WORDS.
REQ-018 o_mem_empty  out  1  loaded word count == 0.
REQ-019 o_halt  out  1  HALT state indicator.

Function
REQ-020 States LOAD, RUN, HALT; LOAD is the reset state.
REQ-021 LOAD: each i_wr_en cycle shifts i_wr_byte into a 4-byte assembler, first byte = MSB (big-endian).
REQ-022 Fourth byte commits assembled word to mem[word_count], word_count increments the same edge.
REQ-023 Bytes written while o_mem_full is high are dropped; assembler and count unchanged.
REQ-024 i_wr_en outside LOAD ignored.
REQ-025 LOAD->RUN on i_start when o_mem_empty low; i_start with empty memory ignored; partial assembler bytes discarded on transition.
REQ-026 RUN, i_enable=1, i_stall=0: PC <= i_pc_src ? i_not_seq_pc : PC+4 next edge; otherwise PC holds.
REQ-027 i_stall dominates i_pc_src; a stalled redirect is lost and must be re-presented by the source.
REQ-028 o_instruction combinational: mem[PC[log2(MEM_WORDS)+1:2]] if that index < word_count, else all-zero (NOP).
REQ-029 PC low two bits ignored for addressing; PC+4 wraps modulo 2^PC_SIZE.
REQ-030 o_next_seq_pc = PC+4 combinational, in every state.
REQ-031 i_clear in any state: next edge PC=0, word_count=0, assembler cleared, state LOAD; i_clear wins over i_start, i_wr_en and PC update.
REQ-032 HALT: PC frozen, o_halt=1, leave only via i_clear or reset.
REQ-033 o_mem_full and o_mem_empty combinational from word_count.

Reset
REQ-034 i_reset low at rising edge: state LOAD, PC=0, word_count=0, assembler cleared; memory array not cleared.
REQ-035 Outputs after reset: o_pc=0, o_next_seq_pc=4, o_instruction=0, o_mem_empty=1, o_mem_full=0, o_halt=0.
REQ-036 Reset takes priority over every other input, including mid-load and mid-run.

Configuration
REQ-037 Macro IF_HALT_DETECT_EN: when defined, RUN with i_enable=1, i_stall=0 and o_instruction == all-ones moves to HALT next edge without advancing PC.
REQ-038 Without IF_HALT_DETECT_EN: no HALT transition, o_halt tied 0, all-ones word fetched as ordinary data.

Verification
REQ-039 Reset; write bytes 0x12,0x34,0x56,0x78; i_start; -> o_instruction=0x12345678, o_pc=0, o_next_seq_pc=4, o_mem_empty=0.
REQ-040 Load 2 words, run 3 enabled cycles -> o_pc 4, 8, 12; at PC=8 o_instruction=0 (beyond loaded count).
REQ-041 RUN, i_pc_src=1, i_not_seq_pc=0x10, i_stall=1 one cycle then 0 -> PC held one cycle, then 0x10.
REQ-042 Write 4*MEM_WORDS+4 bytes -> o_mem_full=1 after word MEM_WORDS, extra 4 bytes dropped, word_count stays MEM_WORDS.
REQ-043 With IF_HALT_DETECT_EN, program {0x00000000, 0xFFFFFFFF}, run -> o_halt=1 with o_pc=4, PC frozen; i_clear -> LOAD, o_pc=0, o_mem_empty=1.
REQ-044 i_reset low mid-load after 2 bytes, then 4 new bytes 0xAABBCCDD and i_start -> o_instruction=0xAABBCCDD.
